// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Left operations reuse the right-shift datapath by reversing the bit order.
package shifter_pkg;

    typedef enum logic [2:0] {
        SLL = 3'd0,
        SRL = 3'd1,
        SRA = 3'd2,
        ROL = 3'd3,
        ROR = 3'd4
    } shift_op_e;

    typedef enum logic [1:0] {
        FILL_ZERO = 2'd0,
        FILL_SIGN = 2'd1,
        FILL_ROT  = 2'd2
    } fill_mode_e;

    // Widest operand bit_reverse can handle.
    localparam int MAX_WIDTH = 256;

    // Reverses the low w bits of d. The full-width mirror lands the operand in
    // the top w bits, so a right shift brings it back to bit 0.
    function automatic logic [MAX_WIDTH-1:0] bit_reverse(input logic [MAX_WIDTH-1:0] d,
                                                         input int w);
        logic [MAX_WIDTH-1:0] r;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            r[i] = d[MAX_WIDTH-1-i];
        end
        return r >> (MAX_WIDTH - w);
    endfunction

    function automatic logic is_left_op(input logic [2:0] op);
        return (op == SLL) || (op == ROL);
    endfunction

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= 3'(ROR);
    endfunction

    function automatic logic [1:0] fill_for_op(input logic [2:0] op);
        case (op)
            3'(SRA):          return FILL_SIGN;
            3'(ROL), 3'(ROR): return FILL_ROT;
            default:          return FILL_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational log-level of the shifter: optional right shift by DIST with
// zero, sign or rotate fill.
module shift_level
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             enable,
    input  logic [1:0]       fill_mode,
    input  logic             sign,
    output logic [WIDTH-1:0] data_out
);

    logic [DIST-1:0] fill;

    always_comb begin
        case (fill_mode)
            FILL_ROT:  fill = data_in[DIST-1:0];
            FILL_SIGN: fill = {DIST{sign}};
            default:   fill = '0;
        endcase
        data_out = enable ? {fill, data_in[WIDTH-1:DIST]} : data_in;
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined SLL/SRL/SRA/ROL/ROR unit with valid/ready handshake, flush and a
// sideband tag. The whole pipe advances together whenever the output can move.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int LVL_PER_STG = 1,
    parameter int TAG_W       = 5
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [2:0]               i_op,
    input  logic [WIDTH-1:0]         i_data,
    input  logic [$clog2(WIDTH)-1:0] i_amt,
    input  logic [TAG_W-1:0]         i_tag,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [WIDTH-1:0]         o_data,
    output logic [TAG_W-1:0]         o_tag
);

    localparam int SHW     = $clog2(WIDTH);
    localparam int LEVELS  = SHW;
    localparam int LATENCY = (LEVELS + LVL_PER_STG - 1) / LVL_PER_STG;

    logic             adv;
    logic [WIDTH-1:0] entry_data;
    logic [SHW-1:0]   entry_amt;
    logic             entry_sign;

    assign adv     = !o_valid || i_ready;
    assign o_ready = adv;

    // Illegal encodings run with a zero amount so the operand passes through.
    always_comb begin
        entry_data = is_left_op(i_op) ? WIDTH'(bit_reverse(MAX_WIDTH'(i_data), WIDTH)) : i_data;
        entry_amt  = is_legal_op(i_op) ? i_amt : '0;
        entry_sign = i_data[WIDTH-1];
    end

    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_stage
            localparam int END_LVL  = ((gi + 1) * LVL_PER_STG < LEVELS) ? (gi + 1) * LVL_PER_STG : LEVELS;
            localparam int LAST_LVL = END_LVL - 1;

            logic             stg_valid;
            logic [WIDTH-1:0] stg_data;
            logic [SHW-1:0]   stg_amt;
            logic [2:0]       stg_op;
            logic             stg_sign;
            logic [TAG_W-1:0] stg_tag;
            logic [1:0]       stg_fill;

            logic             valid_reg;
            logic [WIDTH-1:0] data_reg;
            logic [2:0]       op_reg;
            logic [TAG_W-1:0] tag_reg;

            if (gi == 0) begin : g_src
                assign stg_valid = i_valid;
                assign stg_data  = entry_data;
                assign stg_amt   = entry_amt;
                assign stg_op    = i_op;
                assign stg_sign  = entry_sign;
                assign stg_tag   = i_tag;
            end else begin : g_src
                assign stg_valid = g_stage[gi-1].valid_reg;
                assign stg_data  = g_stage[gi-1].data_reg;
                assign stg_amt   = g_stage[gi-1].g_fwd.amt_reg;
                assign stg_op    = g_stage[gi-1].op_reg;
                assign stg_sign  = g_stage[gi-1].g_fwd.sign_reg;
                assign stg_tag   = g_stage[gi-1].tag_reg;
            end

            assign stg_fill = fill_for_op(stg_op);

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                    op_reg    <= '0;
                    tag_reg   <= '0;
                end else if (i_flush) begin
                    valid_reg <= 1'b0;
                end else if (adv) begin
                    valid_reg <= stg_valid;
                    data_reg  <= g_level[LAST_LVL].lvl_out;
                    op_reg    <= stg_op;
                    tag_reg   <= stg_tag;
                end
            end

            // Amount and sign are only needed by stages that still have levels to run.
            if (gi < LATENCY - 1) begin : g_fwd
                logic [SHW-1:0] amt_reg;
                logic           sign_reg;

                always_ff @(posedge i_clk) begin
                    if (!i_rst_n) begin
                        amt_reg  <= '0;
                        sign_reg <= 1'b0;
                    end else if (!i_flush && adv) begin
                        amt_reg  <= stg_amt;
                        sign_reg <= stg_sign;
                    end
                end
            end
        end

        for (gi = 0; gi < LEVELS; gi++) begin : g_level
            localparam int STG = gi / LVL_PER_STG;

            logic [WIDTH-1:0] lvl_in;
            logic [WIDTH-1:0] lvl_out;

            if (gi % LVL_PER_STG == 0) begin : g_in
                assign lvl_in = g_stage[STG].stg_data;
            end else begin : g_in
                assign lvl_in = g_level[gi-1].lvl_out;
            end

            shift_level #(
                .WIDTH (WIDTH),
                .DIST  (1 << gi)
            ) u_level (
                .data_in   (lvl_in),
                .enable    (g_stage[STG].stg_amt[gi]),
                .fill_mode (g_stage[STG].stg_fill),
                .sign      (g_stage[STG].stg_sign),
                .data_out  (lvl_out)
            );
        end
    endgenerate

    assign o_valid = g_stage[LATENCY-1].valid_reg;
    assign o_tag   = g_stage[LATENCY-1].tag_reg;
    assign o_data  = is_left_op(g_stage[LATENCY-1].op_reg)
                   ? WIDTH'(bit_reverse(MAX_WIDTH'(g_stage[LATENCY-1].data_reg), WIDTH))
                   : g_stage[LATENCY-1].data_reg;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed vectors, stall/flush/reset sequences on the 32-bit default shifter,
// and a randomized reference-model run on a 16-bit, two-level-per-stage copy.
module tb_pipelined_barrel_shifter;
    import shifter_pkg::*;

    localparam int LAT_A = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_flush, a_valid, a_o_ready, a_i_ready, a_o_valid;
    logic [2:0]  a_op;
    logic [31:0] a_data, a_o_data;
    logic [4:0]  a_amt, a_tag, a_o_tag;

    logic        b_flush, b_valid, b_o_ready, b_i_ready, b_o_valid;
    logic [2:0]  b_op;
    logic [15:0] b_data, b_o_data;
    logic [3:0]  b_amt;
    logic [4:0]  b_tag, b_o_tag;

    pipelined_barrel_shifter dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(a_flush), .i_valid(a_valid),
        .o_ready(a_o_ready), .i_op(a_op), .i_data(a_data), .i_amt(a_amt),
        .i_tag(a_tag), .o_valid(a_o_valid), .i_ready(a_i_ready),
        .o_data(a_o_data), .o_tag(a_o_tag)
    );

    pipelined_barrel_shifter #(.WIDTH(16), .LVL_PER_STG(2), .TAG_W(5)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(b_flush), .i_valid(b_valid),
        .o_ready(b_o_ready), .i_op(b_op), .i_data(b_data), .i_amt(b_amt),
        .i_tag(b_tag), .o_valid(b_o_valid), .i_ready(b_i_ready),
        .o_data(b_o_data), .o_tag(b_o_tag)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic [4:0]  amt;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [4:0]  tag;
    } exp_t;

    vec_t vecs[18];
    exp_t q[$];

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] d,
                                input logic [4:0] amt, input logic [31:0] exp);
        vec_t v;
        v.op = op; v.data = d; v.amt = amt; v.exp = exp;
        return v;
    endfunction

    function automatic logic [15:0] ref16(input logic [2:0] op, input logic [15:0] d,
                                          input logic [3:0] a);
        logic [31:0]        dd;
        logic signed [15:0] s;
        dd = {d, d};
        s  = d;
        case (op)
            3'd0: return d << a;
            3'd1: return d >> a;
            3'd2: return 16'(s >>> a);
            3'd3: begin dd = dd << a; return dd[31:16]; end
            3'd4: begin dd = dd >> a; return dd[15:0]; end
            default: return d;
        endcase
    endfunction

    task automatic send_one(input string nm, input logic [2:0] op, input logic [31:0] d,
                            input logic [4:0] amt, input logic [4:0] tag, input logic [31:0] exp);
        int lat;
        a_op = op; a_data = d; a_amt = amt; a_tag = tag; a_valid = 1'b1; a_i_ready = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        lat = 1;
        while (!a_o_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_latency"}, lat, LAT_A);
        check({nm, "_data"}, a_o_data, exp);
        check({nm, "_tag"}, {27'd0, a_o_tag}, {27'd0, tag});
        @(posedge clk); #1;
    endtask

    task automatic count_idle_valids(input string nm);
        int n;
        n = 0;
        a_i_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (a_o_valid) n++;
            @(posedge clk); #1;
        end
        check(nm, n, 0);
    endtask

    task automatic issue_three(input logic [4:0] tag0);
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1; a_op = SRL; a_data = 32'hDEAD_BEEF; a_amt = 5'(i);
            a_tag = tag0 + 5'(i);
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        int sent, got, acc;
        logic [31:0] held;
        logic held_v;
        exp_t e;

        vecs[0]  = mk(SRA,  32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        vecs[1]  = mk(SRL,  32'h8000_0000, 5'd31, 32'h0000_0001);
        vecs[2]  = mk(SLL,  32'h0000_0001, 5'd31, 32'h8000_0000);
        vecs[3]  = mk(ROL,  32'h8000_0001, 5'd4,  32'h0000_0018);
        vecs[4]  = mk(ROR,  32'h0000_0001, 5'd1,  32'h8000_0000);
        vecs[5]  = mk(SLL,  32'hA5C3_0F96, 5'd0,  32'hA5C3_0F96);
        vecs[6]  = mk(SRL,  32'hA5C3_0F96, 5'd0,  32'hA5C3_0F96);
        vecs[7]  = mk(SRA,  32'hA5C3_0F96, 5'd0,  32'hA5C3_0F96);
        vecs[8]  = mk(ROL,  32'hA5C3_0F96, 5'd0,  32'hA5C3_0F96);
        vecs[9]  = mk(ROR,  32'hA5C3_0F96, 5'd0,  32'hA5C3_0F96);
        vecs[10] = mk(3'd7, 32'hA5C3_0F96, 5'd5,  32'hA5C3_0F96);
        vecs[11] = mk(3'd5, 32'h1234_5678, 5'd3,  32'h1234_5678);
        vecs[12] = mk(SRA,  32'h7000_0000, 5'd4,  32'h0700_0000);
        vecs[13] = mk(ROR,  32'h1234_5678, 5'd8,  32'h7812_3456);
        vecs[14] = mk(SLL,  32'h1234_5678, 5'd4,  32'h2345_6780);
        vecs[15] = mk(ROL,  32'h1234_5678, 5'd31, 32'h091A_2B3C);
        vecs[16] = mk(SRA,  32'h8000_0000, 5'd1,  32'hC000_0000);
        vecs[17] = mk(ROR,  32'h1234_5678, 5'd31, 32'h2468_ACF0);

        rst_n = 1'b0;
        a_flush = 0; a_valid = 0; a_i_ready = 1; a_op = 0; a_data = 0; a_amt = 0; a_tag = 0;
        b_flush = 0; b_valid = 0; b_i_ready = 1; b_op = 0; b_data = 0; b_amt = 0; b_tag = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_a_valid", {31'd0, a_o_valid}, 0);
        check("reset_a_data", a_o_data, 0);
        check("reset_a_tag", {27'd0, a_o_tag}, 0);
        check("reset_a_ready", {31'd0, a_o_ready}, 1);
        check("reset_b_valid", {31'd0, b_o_valid}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) begin
            send_one($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].amt,
                     5'(i * 3 + 1), vecs[i].exp);
        end

        // Eight back-to-back SRLs with the consumer stalling for three cycles.
        sent = 0; got = 0; held = 0; held_v = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            a_valid = (sent < 8); a_op = SRL; a_data = 32'hF000_0000;
            a_amt = 5'(sent); a_tag = 5'(sent);
            a_i_ready = !(cyc >= LAT_A + 1 && cyc <= LAT_A + 3);
            #1;
            if (a_o_valid && !a_i_ready) begin
                check("stall_ready", {31'd0, a_o_ready}, 0);
                if (held_v) check("stall_hold", a_o_data, held);
                held = a_o_data; held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            if (a_o_valid && a_i_ready) begin
                check($sformatf("stream%0d_data", got), a_o_data, 32'hF000_0000 >> got);
                check($sformatf("stream%0d_tag", got), {27'd0, a_o_tag}, 32'(got));
                got++;
            end
            if (a_valid && a_o_ready) sent++;
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
        check("stream_count", got, 8);
        $display("stream: sent %0d received %0d", sent, got);

        // Flush while the oldest op sits at the output and a new op is offered.
        a_i_ready = 1'b1;
        issue_three(5'd20);
        a_i_ready = 1'b0;
        issue_three(5'd20);
        check("flush_pre_valid", {31'd0, a_o_valid}, 1);
        a_flush = 1'b1; a_valid = 1'b1; a_tag = 5'd31;
        @(posedge clk); #1;
        a_flush = 1'b0; a_valid = 1'b0;
        check("flush_valid", {31'd0, a_o_valid}, 0);
        count_idle_valids("flush_stale");
        send_one("post_flush", SRL, 32'h8000_0000, 5'd31, 5'd9, 32'h0000_0001);

        // Reset mid-stream with a held result at the output.
        a_i_ready = 1'b0;
        issue_three(5'd5);
        check("reset_pre_valid", {31'd0, a_o_valid}, 1);
        check("reset_pre_data", a_o_data, 32'hDEAD_BEEF);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midreset_valid", {31'd0, a_o_valid}, 0);
        check("midreset_data", a_o_data, 0);
        check("midreset_tag", {27'd0, a_o_tag}, 0);
        count_idle_valids("midreset_stale");
        send_one("post_reset", ROL, 32'h8000_0001, 5'd4, 5'd12, 32'h0000_0018);

        // Random traffic on the 16-bit copy against the reference model.
        acc = 0;
        for (int cyc = 0; cyc < 40000 && acc < 10000; cyc++) begin
            b_valid = ($urandom_range(0, 3) != 0);
            b_op = 3'($urandom_range(0, 7));
            b_data = 16'($urandom); b_amt = 4'($urandom); b_tag = 5'($urandom);
            b_i_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (b_o_valid && b_i_ready) begin
                if (q.size() == 0) begin
                    check("rand_spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("rand_data", {16'd0, b_o_data}, {16'd0, e.data});
                    check("rand_tag", {27'd0, b_o_tag}, {27'd0, e.tag});
                end
            end
            if (b_valid && b_o_ready) begin
                e.data = ref16(b_op, b_data, b_amt); e.tag = b_tag;
                q.push_back(e);
                acc++;
            end
            @(posedge clk); #1;
        end
        b_valid = 1'b0; b_i_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (b_o_valid) begin
                if (q.size() == 0) begin
                    check("rand_spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("rand_drain_data", {16'd0, b_o_data}, {16'd0, e.data});
                    check("rand_drain_tag", {27'd0, b_o_tag}, {27'd0, e.tag});
                end
            end
            @(posedge clk); #1;
        end
        check("rand_accepted", acc, 10000);
        check("rand_left", q.size(), 0);
        $display("random: accepted %0d ops", acc);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
